// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the add/subtract pipeline.
// Holds rounding-mode encodings, fflags bit positions, the operand class
// type, the canonical-NaN generator and small classification/rounding helpers.
package fp_pkg;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  localparam int unsigned FLAG_NV = 4;
  localparam int unsigned FLAG_DZ = 3;
  localparam int unsigned FLAG_OF = 2;
  localparam int unsigned FLAG_UF = 1;
  localparam int unsigned FLAG_NX = 0;

  // Widest format the NaN generator supports
  localparam int unsigned MAX_FLEN = 64;

  typedef enum logic [2:0] {ZERO, SUB, NORM, INF, QNAN, SNAN} fp_class_t;

  // Positive quiet NaN with only the mantissa MSB set, right-aligned in MAX_FLEN bits
  function automatic logic [MAX_FLEN-1:0] canonical_nan(input int unsigned exp_w,
                                                        input int unsigned man_w);
    logic [MAX_FLEN-1:0] nan;
    nan = '0;
    for (int unsigned i = 0; i < exp_w; i++) nan[man_w+i] = 1'b1;
    nan[man_w-1] = 1'b1;
    return nan;
  endfunction

  // Operand class from exponent/mantissa summary bits
  function automatic fp_class_t classify(input logic exp_zero, input logic exp_ones,
                                         input logic man_zero, input logic man_msb);
    fp_class_t cls;
    if (exp_zero)      cls = man_zero ? ZERO : SUB;
    else if (exp_ones) cls = man_zero ? INF : (man_msb ? QNAN : SNAN);
    else               cls = NORM;
    return cls;
  endfunction

  // Round-increment decision; reserved modes behave as RNE
  function automatic logic rnd_up(input logic [2:0] mode, input logic sign,
                                  input logic lsb, input logic g, input logic st);
    logic up;
    case (mode)
      RM_RTZ:  up = 1'b0;
      RM_RDN:  up = (g | st) & sign;
      RM_RUP:  up = (g | st) & ~sign;
      RM_RMM:  up = g;
      default: up = g & (st | lsb);
    endcase
    return up;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter.
// Ports: value (W bits) in; count out = number of leading zeros, W when value is 0.
module fp_lzc #(
  parameter int unsigned W = 27
) (
  input  logic [W-1:0]           value,
  output logic [$clog2(W+1)-1:0] count
);
  localparam int unsigned CW = $clog2(W + 1);

  // Scan upward so the highest set bit wins
  always_comb begin
    count = CW'(W);
    for (int unsigned i = 0; i < W; i++) begin
      if (value[i]) count = CW'(W - 1 - i);
    end
  end
endmodule

// File: rtl/fadd_fsub_pipe.sv
// Three-stage IEEE-754 add/subtract unit with valid/ready handshake and flush.
// Ports:
//   CLK, RST (sync, active-high), Flush (drops all in-flight ops)
//   in_valid/in_ready, Funct (0 add, 1 sub), rm (rounding mode), frs1, frs2
//   out_valid/out_ready, frd (result), fflags {NV,DZ,OF,UF,NX}
// Stages: S1 unpack/align/specials, S2 add/normalise, S3 round/pack into the
// output register. One shared stall enable freezes every bank.
module fadd_fsub_pipe
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 Flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 Funct,
  input  logic [2:0]           rm,
  input  logic [EXP_W+MAN_W:0] frs1,
  input  logic [EXP_W+MAN_W:0] frs2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] frd,
  output logic [4:0]           fflags
);
  localparam int unsigned FLEN  = 1 + EXP_W + MAN_W;
  localparam int unsigned SIG_W = MAN_W + 1;   // hidden + stored mantissa
  localparam int unsigned SH_W  = MAN_W + 3;   // significand + G + R
  localparam int unsigned FW    = MAN_W + 4;   // significand + G + R + S
  localparam int unsigned LZC_W = $clog2(FW + 1);
  localparam logic [EXP_W-1:0] EXP_ONES  = '1;
  localparam logic [FLEN-1:0]  CANON_NAN = FLEN'(canonical_nan(EXP_W, MAN_W));

  typedef struct packed {
    logic             special;
    logic [FLEN-1:0]  spec_res;
    logic             spec_nv;
    logic [2:0]       rm;
    logic             sign;
    logic             eff_sub;
    logic [EXP_W-1:0] exp;
    logic [FW-1:0]    mx;
    logic [FW-1:0]    my;
  } s1_t;

  typedef struct packed {
    logic             special;
    logic [FLEN-1:0]  spec_res;
    logic             spec_nv;
    logic [2:0]       rm;
    logic             sign;
    logic [EXP_W:0]   exp;
    logic [FW-1:0]    m;
  } s2_t;

  logic            stall;
  logic            s1_valid;
  logic            s2_valid;
  s1_t             s1_c;
  s1_t             s1_q;
  s2_t             s2_c;
  s2_t             s2_q;
  logic [FLEN-1:0] frd_c;
  logic [4:0]      fflags_c;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // ---------------- S1: unpack, order by magnitude, align ----------------
  logic              sa;
  logic              sb;
  logic [EXP_W-1:0]  ea;
  logic [EXP_W-1:0]  eb;
  logic [MAN_W-1:0]  ma;
  logic [MAN_W-1:0]  mb;
  fp_class_t         cls_a;
  fp_class_t         cls_b;
  logic              swap;
  logic [EXP_W-1:0]  ex;
  logic [EXP_W-1:0]  ey;
  logic [EXP_W-1:0]  ed;
  logic [SIG_W-1:0]  sig_x;
  logic [SIG_W-1:0]  sig_y;
  logic [2*SH_W-1:0] y_wide;
  int unsigned       sh1;

  always_comb begin
    s1_c  = '0;
    sa    = frs1[FLEN-1];
    sb    = frs2[FLEN-1] ^ Funct;
    ea    = frs1[FLEN-2:MAN_W];
    eb    = frs2[FLEN-2:MAN_W];
    ma    = frs1[MAN_W-1:0];
    mb    = frs2[MAN_W-1:0];
    cls_a = classify(ea == '0, ea == EXP_ONES, ma == '0, ma[MAN_W-1]);
    cls_b = classify(eb == '0, eb == EXP_ONES, mb == '0, mb[MAN_W-1]);

    // Raw {exp,man} ordering matches magnitude ordering, subnormals included
    swap = {eb, mb} > {ea, ma};
    if (swap) begin
      ex    = (eb == '0) ? EXP_W'(1) : eb;
      ey    = (ea == '0) ? EXP_W'(1) : ea;
      sig_x = {eb != '0, mb};
      sig_y = {ea != '0, ma};
    end else begin
      ex    = (ea == '0) ? EXP_W'(1) : ea;
      ey    = (eb == '0) ? EXP_W'(1) : eb;
      sig_x = {ea != '0, ma};
      sig_y = {eb != '0, mb};
    end
    ed  = ex - ey;
    sh1 = (32'(ed) >= SH_W) ? SH_W : 32'(ed);

    // Lower half of the wide shift collects everything that falls past R
    y_wide = {sig_y, 2'b00, {SH_W{1'b0}}} >> sh1;

    s1_c.rm      = rm;
    s1_c.sign    = swap ? sb : sa;
    s1_c.eff_sub = sa ^ sb;
    s1_c.exp     = ex;
    s1_c.mx      = {sig_x, 3'b000};
    s1_c.my      = {y_wide[2*SH_W-1:SH_W], |y_wide[SH_W-1:0]};

    // Special operands bypass the arithmetic result
    s1_c.special  = 1'b1;
    s1_c.spec_nv  = 1'b0;
    s1_c.spec_res = CANON_NAN;
    if (cls_a == SNAN || cls_b == SNAN) begin
      s1_c.spec_nv = 1'b1;
    end else if (cls_a == QNAN || cls_b == QNAN) begin
      s1_c.spec_nv = 1'b0;
    end else if (cls_a == INF && cls_b == INF) begin
      if (sa != sb) s1_c.spec_nv = 1'b1;
      else          s1_c.spec_res = {sa, EXP_ONES, {MAN_W{1'b0}}};
    end else if (cls_a == INF) begin
      s1_c.spec_res = {sa, EXP_ONES, {MAN_W{1'b0}}};
    end else if (cls_b == INF) begin
      s1_c.spec_res = {sb, EXP_ONES, {MAN_W{1'b0}}};
    end else begin
      s1_c.special = 1'b0;
    end
  end

  // ---------------- S2: add/subtract and normalise ----------------
  logic [FW:0]        sum;
  logic [LZC_W-1:0]   lz;
  logic [EXP_W-1:0]   lim;
  int unsigned        sh2;

  assign sum = s1_q.eff_sub ? ({1'b0, s1_q.mx} - {1'b0, s1_q.my})
                            : ({1'b0, s1_q.mx} + {1'b0, s1_q.my});

  fp_lzc #(.W(FW)) u_lzc (
    .value (sum[FW-1:0]),
    .count (lz)
  );

  always_comb begin
    s2_c          = '0;
    s2_c.special  = s1_q.special;
    s2_c.spec_res = s1_q.spec_res;
    s2_c.spec_nv  = s1_q.spec_nv;
    s2_c.rm       = s1_q.rm;
    s2_c.sign     = s1_q.sign;
    lim           = s1_q.exp - EXP_W'(1);
    sh2           = 0;
    if (sum[FW]) begin
      // Carry-out: shift right one, folding the dropped bit into sticky
      s2_c.m   = {sum[FW:2], sum[1] | sum[0]};
      s2_c.exp = {1'b0, s1_q.exp} + (EXP_W+1)'(1);
    end else begin
      // Left shift clamped so the exponent bottoms out at 1 (subnormal)
      sh2      = (32'(lz) > 32'(lim)) ? 32'(lim) : 32'(lz);
      s2_c.m   = sum[FW-1:0] << sh2;
      s2_c.exp = {1'b0, s1_q.exp} - (EXP_W+1)'(sh2);
    end
    // Exact zero: true subtraction yields +0 except under RDN
    if (sum == '0) s2_c.sign = s1_q.eff_sub ? (s1_q.rm == RM_RDN) : s1_q.sign;
  end

  // ---------------- S3: round, detect overflow/underflow, pack ----------------
  logic [SIG_W-1:0]  sig3;
  logic [SIG_W:0]    sig_r;
  logic              ru;
  logic              ru_alt;
  logic              inexact;
  logic              tiny;
  logic              ovf;
  logic              hid_r;
  logic [EXP_W:0]    exp_r;
  logic [EXP_W-1:0]  exp_field;
  logic [MAN_W-1:0]  man_r;
  logic [FLEN-1:0]   inf_res;
  logic [FLEN-1:0]   max_res;

  always_comb begin
    frd_c    = '0;
    fflags_c = '0;
    sig3     = s2_q.m[FW-1:3];
    inexact  = |s2_q.m[2:0];
    ru       = rnd_up(s2_q.rm, s2_q.sign, s2_q.m[3], s2_q.m[2], s2_q.m[1] | s2_q.m[0]);
    // Same decision one bit lower: rounding as if the exponent were unbounded
    ru_alt   = rnd_up(s2_q.rm, s2_q.sign, s2_q.m[2], s2_q.m[1], s2_q.m[0]);
    sig_r    = {1'b0, sig3} + (SIG_W+1)'(ru);
    if (sig_r[SIG_W]) begin
      exp_r = s2_q.exp + (EXP_W+1)'(1);
      man_r = '0;
      hid_r = 1'b1;
    end else begin
      exp_r = s2_q.exp;
      man_r = sig_r[MAN_W-1:0];
      hid_r = sig_r[MAN_W];
    end
    exp_field = hid_r ? exp_r[EXP_W-1:0] : EXP_W'(0);
    ovf       = hid_r & (exp_r >= {1'b0, EXP_ONES});
    tiny      = ~sig3[MAN_W] & ~((&sig3[MAN_W-1:0]) & ru_alt);
    inf_res   = {s2_q.sign, EXP_ONES, {MAN_W{1'b0}}};
    max_res   = {s2_q.sign, EXP_ONES - EXP_W'(1), {MAN_W{1'b1}}};

    if (s2_q.special) begin
      frd_c            = s2_q.spec_res;
      fflags_c[FLAG_NV] = s2_q.spec_nv;
    end else if (ovf) begin
      fflags_c[FLAG_OF] = 1'b1;
      fflags_c[FLAG_NX] = 1'b1;
      case (s2_q.rm)
        RM_RTZ:  frd_c = max_res;
        RM_RDN:  frd_c = s2_q.sign ? inf_res : max_res;
        RM_RUP:  frd_c = s2_q.sign ? max_res : inf_res;
        default: frd_c = inf_res;
      endcase
    end else begin
      frd_c             = {s2_q.sign, exp_field, man_r};
      fflags_c[FLAG_UF] = tiny & inexact;
      fflags_c[FLAG_NX] = inexact;
    end
  end

  // ---------------- Pipeline registers ----------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      s1_q      <= '0;
      s2_q      <= '0;
      frd       <= '0;
      fflags    <= '0;
    end else begin
      // Flush wins over stall and also drops the op presented this cycle
      if (Flush) begin
        s1_valid  <= 1'b0;
        s2_valid  <= 1'b0;
        out_valid <= 1'b0;
      end else if (!stall) begin
        s1_valid  <= in_valid;
        s2_valid  <= s1_valid;
        out_valid <= s2_valid;
      end
      if (!stall) begin
        s1_q   <= s1_c;
        s2_q   <= s2_c;
        frd    <= frd_c;
        fflags <= fflags_c;
      end
    end
  end

endmodule

// File: tb/tb_fadd_fsub_pipe.sv
// Directed bench for fadd_fsub_pipe (single precision): arithmetic vectors with
// hand-computed results, latency, backpressure ordering, flush and reset.
module tb_fadd_fsub_pipe;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Flush;
  logic        in_valid;
  logic        in_ready;
  logic        Funct;
  logic [2:0]  rm;
  logic [31:0] frs1;
  logic [31:0] frs2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] frd;
  logic [4:0]  fflags;

  int checks   = 0;
  int failures = 0;

  fadd_fsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .Flush     (Flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Funct     (Funct),
    .rm        (rm),
    .frs1      (frs1),
    .frs2      (frs2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frd       (frd),
    .fflags    (fflags)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One op through an idle pipe: checks latency, result and flags
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic f, input logic [2:0] m,
                        input logic [31:0] want_frd, input logic [4:0] want_flags);
    int lat;
    frs1 = a; frs2 = b; Funct = f; rm = m; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'd3);
    check({tag, "_frd"}, frd, want_frd);
    check({tag, "_flags"}, {27'd0, fflags}, {27'd0, want_flags});
    tick();
  endtask

  logic [31:0] st_a [4];
  logic [31:0] st_b [4];
  logic        st_f [4];
  logic [31:0] st_e [4];

  initial begin
    int n_acc;
    int n_got;
    int seen;
    logic acc;

    RST = 1'b1; Flush = 1'b0; in_valid = 1'b0; Funct = 1'b0; rm = 3'b000;
    frs1 = '0; frs2 = '0; out_ready = 1'b1;
    tick(); tick();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_frd", frd, 32'h0);
    check("rst_fflags", {27'd0, fflags}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    RST = 1'b0;
    tick();

    // Basic arithmetic
    run_op("add_1_2",    32'h3F800000, 32'h40000000, 1'b0, 3'b000, 32'h40400000, 5'h00);
    run_op("sub_x_x_rne", 32'h3F800000, 32'h3F800000, 1'b1, 3'b000, 32'h00000000, 5'h00);
    run_op("sub_x_x_rdn", 32'h3F800000, 32'h3F800000, 1'b1, 3'b010, 32'h80000000, 5'h00);
    run_op("sub_norm",   32'h3F800000, 32'h33800000, 1'b1, 3'b000, 32'h3F7FFFFF, 5'h00);

    // Specials
    run_op("inf_m_inf",  32'h7F800000, 32'hFF800000, 1'b0, 3'b000, 32'h7FC00000, 5'h10);
    run_op("snan",       32'h7F800001, 32'h3F800000, 1'b0, 3'b000, 32'h7FC00000, 5'h10);
    run_op("qnan",       32'h7FC12345, 32'h3F800000, 1'b0, 3'b000, 32'h7FC00000, 5'h00);
    run_op("fin_m_inf",  32'h3F800000, 32'h7F800000, 1'b1, 3'b000, 32'hFF800000, 5'h00);

    // Signed zeros
    run_op("nz_p_nz",    32'h80000000, 32'h80000000, 1'b0, 3'b000, 32'h80000000, 5'h00);
    run_op("pz_p_nz",    32'h00000000, 32'h80000000, 1'b0, 3'b000, 32'h00000000, 5'h00);
    run_op("pz_p_nz_rdn", 32'h00000000, 32'h80000000, 1'b0, 3'b010, 32'h80000000, 5'h00);

    // Overflow in each relevant mode
    run_op("ovf_rne",    32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'b000, 32'h7F800000, 5'h05);
    run_op("ovf_rtz",    32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'b001, 32'h7F7FFFFF, 5'h05);
    run_op("ovf_rdn_p",  32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'b010, 32'h7F7FFFFF, 5'h05);
    run_op("ovf_rdn_n",  32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 3'b010, 32'hFF800000, 5'h05);
    run_op("ovf_rup_n",  32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 3'b011, 32'hFF7FFFFF, 5'h05);

    // Rounding of an exact half-ulp and subnormal boundary
    run_op("tie_rne",    32'h3F800000, 32'h33800000, 1'b0, 3'b000, 32'h3F800000, 5'h01);
    run_op("tie_rup",    32'h3F800000, 32'h33800000, 1'b0, 3'b011, 32'h3F800001, 5'h01);
    run_op("tie_rmm",    32'h3F800000, 32'h33800000, 1'b0, 3'b100, 32'h3F800001, 5'h01);
    run_op("tie_rtz",    32'h3F800000, 32'h33800000, 1'b0, 3'b001, 32'h3F800000, 5'h01);
    run_op("min_m_sub",  32'h00800000, 32'h00000001, 1'b1, 3'b000, 32'h007FFFFF, 5'h00);

    // Backpressure: four ops, consumer stalled for the first five cycles
    st_a[0] = 32'h3F800000; st_b[0] = 32'h3F800000; st_f[0] = 1'b0; st_e[0] = 32'h40000000;
    st_a[1] = 32'h3F800000; st_b[1] = 32'h40000000; st_f[1] = 1'b0; st_e[1] = 32'h40400000;
    st_a[2] = 32'h40000000; st_b[2] = 32'h40000000; st_f[2] = 1'b0; st_e[2] = 32'h40800000;
    st_a[3] = 32'h40000000; st_b[3] = 32'h3F800000; st_f[3] = 1'b1; st_e[3] = 32'h3F800000;
    rm = 3'b000;
    n_acc = 0;
    n_got = 0;
    for (int cyc = 0; cyc < 40 && n_got < 4; cyc++) begin
      out_ready = (cyc >= 5);
      if (n_acc < 4) begin
        in_valid = 1'b1;
        frs1 = st_a[n_acc]; frs2 = st_b[n_acc]; Funct = st_f[n_acc];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && !out_ready) check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      acc = in_valid & in_ready;
      if (out_valid && out_ready) begin
        check($sformatf("stream_%0d", n_got), frd, st_e[n_got]);
        n_got++;
      end
      tick();
      if (acc) n_acc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_count", 32'(n_got), 32'd4);
    tick();
    check("stream_drained", {31'd0, out_valid}, 32'd0);

    // Flush with three ops in flight (third presented in the flush cycle)
    frs1 = 32'h3F800000; frs2 = 32'h40000000; Funct = 1'b0;
    in_valid = 1'b1;
    tick();
    tick();
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    in_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) seen++;
      tick();
    end
    check("flush_no_valid", 32'(seen), 32'd0);
    run_op("after_flush", 32'h3F800000, 32'h40000000, 1'b0, 3'b000, 32'h40400000, 5'h00);

    // Reset with a stalled overflow result sitting in the output register
    out_ready = 1'b0;
    frs1 = 32'h7F7FFFFF; frs2 = 32'h7F7FFFFF; Funct = 1'b0; rm = 3'b000;
    in_valid = 1'b1;
    tick(); tick(); tick();
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    check("pre_rst_flags", {27'd0, fflags}, 32'h05);
    RST = 1'b1;
    tick();
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_frd", frd, 32'h0);
    check("mid_rst_fflags", {27'd0, fflags}, 32'd0);
    RST = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid) seen++;
      tick();
    end
    check("rst_dropped_ops", 32'(seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
